// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer.
// Main register M drives the outputs. Skid register S holds a younger beat
// when the downstream stalls. State is {s_v, m_v}; 2'b10 is unreachable.
module pipe_stage_skid #(
    parameter int unsigned DATA_W   = 83,
    parameter bit          SKID_EN  = 1'b1,
    parameter bit          CLR_DATA = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] r_s_data;

    logic w_m_v;
    logic w_s_v;
    logic w_in_ready;
    logic w_acc;
    logic w_drn;
    logic w_ld_m_in;
    logic w_ld_m_skid;
    logic w_ld_s;

    // Decode valid bits and handshakes; with the skid buffer in_ready has no out_ready path.
    always_comb begin
        w_m_v = r_state[0];
        w_s_v = r_state[1];
        if (SKID_EN) begin
            w_in_ready = ~w_s_v;
        end else begin
            w_in_ready = ~w_m_v | i_out_ready;
        end
        w_acc = i_in_valid & w_in_ready;
        w_drn = w_m_v & i_out_ready;
    end

    // Next state and register load selects; flush empties the stage regardless of handshakes.
    always_comb begin
        w_state_d   = r_state;
        w_ld_m_in   = 1'b0;
        w_ld_m_skid = 1'b0;
        w_ld_s      = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_acc) begin
                    w_state_d = StOne;
                    w_ld_m_in = 1'b1;
                end
            end
            StOne: begin
                if (w_acc && w_drn) begin
                    w_ld_m_in = 1'b1;
                end else if (w_acc && SKID_EN) begin
                    // Downstream stalled: park the younger beat in S.
                    w_state_d = StFull;
                    w_ld_s    = 1'b1;
                end else if (w_drn) begin
                    w_state_d = StEmpty;
                end
            end
            StFull: begin
                if (w_drn) begin
                    w_state_d   = StOne;
                    w_ld_m_skid = 1'b1;
                end
            end
            default: begin
                w_state_d = StEmpty;
            end
        endcase
        if (i_flush) begin
            w_state_d = StEmpty;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Payload registers; flush zeroes them only when CLR_DATA is set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_data <= '0;
            r_s_data <= '0;
        end else if (i_flush) begin
            if (CLR_DATA) begin
                r_m_data <= '0;
                r_s_data <= '0;
            end
        end else begin
            if (w_ld_m_in) begin
                r_m_data <= i_in_data;
            end else if (w_ld_m_skid) begin
                r_m_data <= r_s_data;
            end
            if (w_ld_s) begin
                r_s_data <= i_in_data;
            end
        end
    end

    // Output drive straight from the main register.
    always_comb begin
        o_in_ready  = w_in_ready;
        o_out_valid = w_m_v;
        o_out_data  = r_m_data;
        o_occupancy = {1'b0, w_m_v} + {1'b0, w_s_v};
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one skid instance (a_*) and one single-entry instance (b_*).
// Each instance has a queue-based reference model checked at every falling edge.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 83;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;
    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .CLR_DATA(1'b1)) dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (a_flush),
        .i_in_valid  (a_in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_data   (a_in_data),
        .o_out_valid (a_out_valid),
        .i_out_ready (a_out_ready),
        .o_out_data  (a_out_data),
        .o_occupancy (a_occ)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0), .CLR_DATA(1'b1)) dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (b_flush),
        .i_in_valid  (b_in_valid),
        .o_in_ready  (b_in_ready),
        .i_in_data   (b_in_data),
        .o_out_valid (b_out_valid),
        .i_out_ready (b_out_ready),
        .o_out_data  (b_out_data),
        .o_occupancy (b_occ)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the skid instance: expected beats queued on acceptance, popped on drain.
    logic [DW-1:0] qa[$];
    bit            za = 1'b1;
    always @(negedge clk) begin
        bit er, acc, drn;
        er = (qa.size() < 2);
        check("a.in_ready", a_in_ready, er);
        check("a.out_valid", a_out_valid, qa.size() != 0);
        check("a.occupancy", a_occ, qa.size());
        check("a.state10", !a_out_valid && (a_occ != 2'd0), 1'b0);
        if (qa.size() != 0) check("a.out_data", a_out_data, qa[0]);
        else if (za) check("a.out_data_zero", a_out_data, '0);
        acc = a_in_valid && er;
        drn = (qa.size() != 0) && a_out_ready;
        if (rst || a_flush) begin
            qa.delete();
            za = 1'b1;
        end else begin
            if (drn) void'(qa.pop_front());
            if (acc) begin
                qa.push_back(a_in_data);
                za = 1'b0;
            end
        end
    end

    // Scoreboard for the single-entry instance.
    logic [DW-1:0] qb[$];
    bit            zb = 1'b1;
    always @(negedge clk) begin
        bit er, acc, drn;
        er = (qb.size() == 0) || b_out_ready;
        check("b.in_ready", b_in_ready, er);
        check("b.out_valid", b_out_valid, qb.size() != 0);
        check("b.occupancy", b_occ, qb.size());
        if (qb.size() != 0) check("b.out_data", b_out_data, qb[0]);
        else if (zb) check("b.out_data_zero", b_out_data, '0);
        acc = b_in_valid && er;
        drn = (qb.size() != 0) && b_out_ready;
        if (rst || b_flush) begin
            qb.delete();
            zb = 1'b1;
        end else begin
            if (drn) void'(qb.pop_front());
            if (acc) begin
                qb.push_back(b_in_data);
                zb = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [DW-1:0] d, input logic rdy);
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = rdy;
    endtask

    initial begin
        logic [95:0] rnd;
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // T1: back-to-back stream with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            a_drive(1'b1, DW'(i), 1'b1);
            @(negedge clk);
            check("t1.in_ready", a_in_ready, 1'b1);
            if (i > 1) begin
                check("t1.occ", a_occ, 2'd1);
                check("t1.data", a_out_data, DW'(i - 1));
            end
            tick();
        end
        a_drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("t1.last", a_out_data, DW'(8));
        tick();

        // T2: stall fills the skid, 0xC waits, then drains in order.
        a_drive(1'b1, DW'('hA), 1'b0);
        tick();
        a_drive(1'b1, DW'('hB), 1'b0);
        tick();
        a_drive(1'b1, DW'('hC), 1'b0);
        @(negedge clk);
        check("t2.occ_full", a_occ, 2'd2);
        check("t2.in_ready", a_in_ready, 1'b0);
        check("t2.hold_a", a_out_data, DW'('hA));
        tick();
        @(negedge clk);
        check("t2.still_full", a_occ, 2'd2);
        tick();
        a_drive(1'b1, DW'('hC), 1'b1);
        @(negedge clk);
        check("t2.out_a", a_out_data, DW'('hA));
        check("t2.rdy_reg", a_in_ready, 1'b0);
        tick();
        @(negedge clk);
        check("t2.out_b", a_out_data, DW'('hB));
        check("t2.rdy_back", a_in_ready, 1'b1);
        tick();
        a_drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("t2.out_c", a_out_data, DW'('hC));
        tick();
        @(negedge clk);
        check("t2.empty", a_occ, 2'd0);

        // T3: flush a full stage while a new beat is offered.
        a_drive(1'b1, DW'('h5), 1'b0);
        tick();
        a_drive(1'b1, DW'('h6), 1'b0);
        tick();
        a_drive(1'b1, DW'('h7), 1'b0);
        a_flush = 1'b1;
        @(negedge clk);
        check("t3.pre_occ", a_occ, 2'd2);
        tick();
        a_flush = 1'b0;
        a_drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("t3.valid", a_out_valid, 1'b0);
        check("t3.occ", a_occ, 2'd0);
        check("t3.data", a_out_data, '0);
        repeat (3) tick();

        // T4: synchronous reset while full.
        a_drive(1'b1, DW'('h11), 1'b0);
        tick();
        a_drive(1'b1, DW'('h12), 1'b0);
        tick();
        a_drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t4.pre_occ", a_occ, 2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4.valid", a_out_valid, 1'b0);
        check("t4.data", a_out_data, '0);
        check("t4.occ", a_occ, 2'd0);
        check("t4.in_ready", a_in_ready, 1'b1);
        tick();

        // T5: single-entry mode, combinational in_ready from out_ready.
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = DW'('h3);
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("t5.stall_rdy", b_in_ready, 1'b0);
        check("t5.hold", b_out_data, DW'('h3));
        tick();
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = DW'('h4);
        @(negedge clk);
        check("t5.comb_rdy", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("t5.next", b_out_data, DW'('h4));
        check("t5.occ", b_occ, 2'd1);
        tick();

        // T6: random valid/ready with occasional flush, both instances.
        for (int c = 0; c < 10000; c++) begin
            rnd = {$urandom, $urandom, $urandom};
            a_in_valid  = $urandom_range(0, 1) == 1;
            a_out_ready = $urandom_range(0, 3) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0;
            a_in_data   = rnd[DW-1:0];
            a_flush     = $urandom_range(0, 99) == 0;
            rnd = {$urandom, $urandom, $urandom};
            b_in_valid  = $urandom_range(0, 1) == 1;
            b_out_ready = $urandom_range(0, 1) == 1;
            b_in_data   = rnd[DW-1:0];
            b_flush     = $urandom_range(0, 99) == 0;
            tick();
        end
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("end.a_empty", a_occ, 2'd0);
        check("end.b_empty", b_occ, 2'd0);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
